// File: rtl/ioctl_upload_reader_if.sv
// Bundle of the hps_io upload side and the byte-wide memory read port.
// The reader sits on the slave side; the hps_io/memory environment drives the master side.
interface ioctl_upload_reader_if #(
    parameter int unsigned AW = 14
);
    logic          ioctl_upload;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_index;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ack;
    logic [7:0]    mem_dout;

    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, mem_ack, mem_dout,
        output ioctl_din, ioctl_wait, mem_addr, mem_rd
    );

    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, ioctl_index, mem_ack, mem_dout,
        input  ioctl_din, ioctl_wait, mem_addr, mem_rd
    );
endinterface

// File: rtl/ioctl_upload_reader.sv
// Serves hps_io upload byte reads from a byte-wide memory. In-range reads for our index
// stall hps_io until the memory acks or a timeout expires. Other reads are answered at once.
module ioctl_upload_reader #(
    parameter int unsigned AW      = 14,
    parameter int unsigned SIZE    = 16384,
    parameter logic [7:0]  INDEX   = 8'd0,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    ioctl_upload_reader_if.slave bus,
    output logic                 upload_done,
    output logic                 upload_err,
    output logic [24:0]          byte_count
);
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    din_q, din_d;
    logic          wait_q, wait_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [24:0]   count_q, count_d;
    logic          up_q, up_d;

    logic          in_range;
    logic          timer_expired;

    assign in_range      = ({7'd0, bus.ioctl_addr} < SIZE);
    assign timer_expired = (timer_q == TW'(TIMEOUT));

    // Next-state: session edges first, then per-state request handling.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        din_d   = din_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        err_d   = err_q;
        count_d = count_q;
        up_d    = bus.ioctl_upload;
        done_d  = up_q & ~bus.ioctl_upload;

        // A new session restarts the statistics; a read in the same cycle counts on top.
        if (!up_q && bus.ioctl_upload) begin
            count_d = '0;
            err_d   = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (bus.ioctl_rd && bus.ioctl_upload) begin
                    if (bus.ioctl_index != INDEX) begin
                        din_d   = 8'h00;
                        count_d = count_d + 25'd1;
                    end else if (!in_range) begin
                        din_d   = 8'hFF;
                        count_d = count_d + 25'd1;
                    end else begin
                        addr_d  = bus.ioctl_addr[AW-1:0];
                        rd_d    = 1'b1;
                        wait_d  = 1'b1;
                        timer_d = '0;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                if (!bus.ioctl_upload) begin
                    // Session ended under us: abandon the byte without counting it.
                    rd_d    = 1'b0;
                    wait_d  = 1'b0;
                    state_d = StIdle;
                end else if (bus.mem_ack) begin
                    din_d   = bus.mem_dout;
                    rd_d    = 1'b0;
                    wait_d  = 1'b0;
                    count_d = count_d + 25'd1;
                    state_d = StIdle;
                end else if (timer_expired) begin
                    din_d   = 8'hFF;
                    err_d   = 1'b1;
                    rd_d    = 1'b0;
                    wait_d  = 1'b0;
                    count_d = count_d + 25'd1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            din_q   <= din_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
            up_q    <= up_d;
        end
    end

    assign bus.ioctl_din  = din_q;
    assign bus.ioctl_wait = wait_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_rd     = rd_q;
    assign upload_done    = done_q;
    assign upload_err     = err_q;
    assign byte_count     = count_q;
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: transaction-level model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ioctl_upload_reader;
    localparam int unsigned SIZE = 16384;
    localparam int unsigned TMO  = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upload_done;
    logic        upload_err;
    logic [24:0] byte_count;

    ioctl_upload_reader_if #(.AW(14)) bus ();

    ioctl_upload_reader #(
        .AW(14), .SIZE(SIZE), .INDEX(8'd0), .TIMEOUT(TMO)
    ) dut (
        .clk_sys    (clk),
        .reset      (reset),
        .bus        (bus),
        .upload_done(upload_done),
        .upload_err (upload_err),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks ack_delay cycles after mem_rd first appears, or on a forced pulse.
    logic auto_ack = 1'b0;
    int   ack_delay = 3;
    logic late_ack = 1'b0;
    int   rd_cycles = 0;

    always @(negedge clk) begin
        bus.mem_ack = late_ack;
        if (auto_ack && bus.mem_rd) begin
            if (rd_cycles == ack_delay) begin
                bus.mem_ack = 1'b1;
                rd_cycles = 0;
            end else begin
                rd_cycles++;
            end
        end else begin
            rd_cycles = 0;
        end
        bus.mem_dout = bus.mem_addr[7:0] ^ 8'hA0;
    end

    // Behavioural model: one outstanding byte, aged in FETCH cycles; gives up after TMO+1.
    logic        started = 1'b0;
    logic        m_busy = 1'b0;
    int          m_age = 0;
    logic [13:0] m_addr = '0;
    logic [7:0]  m_din = 8'h00;
    logic [24:0] m_count = '0;
    logic        m_err = 1'b0;
    logic        m_done = 1'b0;
    logic        m_prev = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            m_busy = 0; m_age = 0; m_addr = '0; m_din = 8'h00;
            m_count = '0; m_err = 0; m_done = 0; m_prev = 0;
        end else begin
            m_done = m_prev && !bus.ioctl_upload;
            if (!m_prev && bus.ioctl_upload) begin
                m_count = '0;
                m_err = 1'b0;
            end
            if (m_busy) begin
                m_age++;
                if (!bus.ioctl_upload) begin
                    m_busy = 0;
                end else if (bus.mem_ack) begin
                    m_din = bus.mem_dout; m_busy = 0; m_count = m_count + 1;
                end else if (m_age == TMO + 1) begin
                    m_din = 8'hFF; m_err = 1; m_busy = 0; m_count = m_count + 1;
                end
            end else if (bus.ioctl_rd && bus.ioctl_upload) begin
                if (bus.ioctl_index != 8'd0) begin
                    m_din = 8'h00; m_count = m_count + 1;
                end else if (bus.ioctl_addr >= 25'(SIZE)) begin
                    m_din = 8'hFF; m_count = m_count + 1;
                end else begin
                    m_busy = 1; m_addr = bus.ioctl_addr[13:0]; m_age = 0;
                end
            end
            m_prev = bus.ioctl_upload;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            check("m_din",   32'(bus.ioctl_din),  32'(m_din));
            check("m_wait",  32'(bus.ioctl_wait), 32'(m_busy));
            check("m_rd",    32'(bus.mem_rd),     32'(m_busy));
            check("m_addr",  32'(bus.mem_addr),   32'(m_addr));
            check("m_done",  32'(upload_done),    32'(m_done));
            check("m_err",   32'(upload_err),     32'(m_err));
            check("m_count", 32'(byte_count),     32'(m_count));
        end
    end

    task automatic issue(input logic [24:0] addr, input logic [7:0] idx);
        @(negedge clk);
        #1;
        bus.ioctl_addr = addr;
        bus.ioctl_index = idx;
        bus.ioctl_rd = 1'b1;
        @(posedge clk);
        #1;
        bus.ioctl_rd = 1'b0;
    endtask

    task automatic read_wait(input logic [24:0] addr);
        int k;
        issue(addr, 8'd0);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.ioctl_wait && k < 50);
        check("read_done", 32'(bus.ioctl_wait), 32'd0);
    endtask

    int w_cnt, r_cnt, d_cnt;

    initial begin
        bus.ioctl_upload = 1'b0;
        bus.ioctl_rd = 1'b0;
        bus.ioctl_addr = '0;
        bus.ioctl_index = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_din",   32'(bus.ioctl_din), 32'h00);
        check("rst_rd",    32'(bus.mem_rd),    32'd0);
        check("rst_count", 32'(byte_count),    32'd0);
        #1 reset = 1'b0;
        auto_ack = 1'b1;
        ack_delay = 3;
        bus.ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);

        // Normal fetch, ack three cycles after mem_rd.
        issue(25'h5, 8'd0);
        w_cnt = 0; r_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.ioctl_wait) w_cnt++;
            if (bus.mem_rd) r_cnt++;
        end
        check("fetch_wait_cycles", 32'(w_cnt), 32'd4);
        check("fetch_rd_cycles",   32'(r_cnt), 32'd4);
        check("fetch_din",   32'(bus.ioctl_din), 32'hA5);
        check("fetch_addr",  32'(bus.mem_addr),  32'h5);
        check("fetch_count", 32'(byte_count),    32'd1);

        // Out of range.
        issue(25'h4000, 8'd0);
        w_cnt = 0; r_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ioctl_wait) w_cnt++;
            if (bus.mem_rd) r_cnt++;
        end
        check("oor_wait",  32'(w_cnt), 32'd0);
        check("oor_rd",    32'(r_cnt), 32'd0);
        check("oor_din",   32'(bus.ioctl_din), 32'hFF);
        check("oor_count", 32'(byte_count),    32'd2);

        // Foreign index.
        issue(25'h0, 8'd1);
        r_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_rd) r_cnt++;
        end
        check("idx_rd",    32'(r_cnt), 32'd0);
        check("idx_din",   32'(bus.ioctl_din), 32'h00);
        check("idx_count", 32'(byte_count),    32'd3);

        // Withheld ack: timeout after 256 FETCH cycles.
        #1 auto_ack = 1'b0;
        issue(25'h10, 8'd0);
        r_cnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.mem_rd) r_cnt++;
        end
        check("tmo_rd_cycles", 32'(r_cnt), 32'd256);
        check("tmo_din",   32'(bus.ioctl_din), 32'hFF);
        check("tmo_err",   32'(upload_err),    32'd1);
        check("tmo_count", 32'(byte_count),    32'd4);
        #1 late_ack = 1'b1;
        @(negedge clk);
        #1 late_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("late_din",   32'(bus.ioctl_din), 32'hFF);
        check("late_count", 32'(byte_count),    32'd4);
        #1 bus.ioctl_upload = 1'b0;
        repeat (2) @(negedge clk);
        #1 bus.ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);
        check("new_sess_err",   32'(upload_err), 32'd0);
        check("new_sess_count", 32'(byte_count), 32'd0);

        // Session ends during FETCH.
        issue(25'h7, 8'd0);
        repeat (5) @(negedge clk);
        #1 bus.ioctl_upload = 1'b0;
        d_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (upload_done) d_cnt++;
        end
        check("abort_done_pulses", 32'(d_cnt), 32'd1);
        check("abort_rd",    32'(bus.mem_rd),     32'd0);
        check("abort_wait",  32'(bus.ioctl_wait), 32'd0);
        check("abort_count", 32'(byte_count),     32'd0);

        // Reset during FETCH, then back-to-back reads.
        #1 bus.ioctl_upload = 1'b1;
        repeat (2) @(negedge clk);
        issue(25'h9, 8'd0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_fetch_rd",    32'(bus.mem_rd),     32'd0);
        check("rst_fetch_wait",  32'(bus.ioctl_wait), 32'd0);
        check("rst_fetch_done",  32'(upload_done),    32'd0);
        check("rst_fetch_addr",  32'(bus.mem_addr),   32'd0);
        check("rst_fetch_count", 32'(byte_count),     32'd0);
        #1 reset = 1'b0;
        auto_ack = 1'b1;
        ack_delay = 0;
        read_wait(25'h1);
        check("b2b_din1", 32'(bus.ioctl_din), 32'hA1);
        read_wait(25'h2);
        read_wait(25'h3);
        repeat (2) @(negedge clk);
        check("b2b_din3",  32'(bus.ioctl_din), 32'hA3);
        check("b2b_count", 32'(byte_count),    32'd3);
        check("b2b_done",  32'(upload_done),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
